// File: rtl/dft_pkg.sv
// Shared types and helpers for the single-bin DFT engine.
package dft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned TW_WIDTH_DEF = 18;
  localparam int unsigned TW_FRAC_DEF  = 16;

  // Sum of N products plus the two-term add never reaches the extra sign bit.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned tw,
                                            input int unsigned idx);
    return w + tw + idx + 1;
  endfunction

  // Clip a signed value into a w-bit signed range; flags when clipping happened.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int unsigned w,
                                                  output logic clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    clipped = 1'b0;
    if (x > hi) begin
      clipped = 1'b1;
      return hi;
    end
    if (x < lo) begin
      clipped = 1'b1;
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/dft_twiddle_rom.sv
// Registered cos/sin lookup for angle 2*pi*addr/SAMPLES, scaled by 2^TW_FRAC.
module dft_twiddle_rom #(
  parameter int unsigned SAMPLES   = 32,
  parameter int unsigned TW_WIDTH  = 18,
  parameter int unsigned TW_FRAC   = 16,
  parameter int unsigned IDX_WIDTH = $clog2(SAMPLES)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [IDX_WIDTH-1:0]       addr,
  output logic signed [TW_WIDTH-1:0] cos_o,
  output logic signed [TW_WIDTH-1:0] sin_o
);

  localparam real         PI    = 3.14159265358979323846;
  localparam int unsigned ONE   = 1 << TW_FRAC;
  localparam real         SCALE = real'(ONE);

  logic signed [TW_WIDTH-1:0] cos_tab [SAMPLES];
  logic signed [TW_WIDTH-1:0] sin_tab [SAMPLES];
  logic signed [TW_WIDTH-1:0] cos_d, sin_d;

  // Table contents fixed at elaboration, rounded to nearest.
  for (genvar g = 0; g < SAMPLES; g++) begin : g_tab
    localparam real ANG = 2.0 * PI * real'(g) / real'(SAMPLES);
    localparam real CR  = $cos(ANG) * SCALE;
    localparam real SR  = $sin(ANG) * SCALE;
    localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
    localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
    assign cos_tab[g] = TW_WIDTH'(CI);
    assign sin_tab[g] = TW_WIDTH'(SI);
  end

  always_comb begin
    cos_d = cos_tab[addr];
    sin_d = sin_tab[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cos_o <= '0;
      sin_o <= '0;
    end else begin
      cos_o <= cos_d;
      sin_o <= sin_d;
    end
  end

endmodule

// File: rtl/dft_bin_engine.sv
// Sequential single-bin forward DFT: one complex MAC iterated over all samples.
module dft_bin_engine
  import dft_pkg::*;
#(
  parameter int unsigned SAMPLES   = 32,
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned FRAC      = 8,
  parameter int unsigned TW_WIDTH  = TW_WIDTH_DEF,
  parameter int unsigned TW_FRAC   = TW_FRAC_DEF,
  parameter int unsigned IDX_WIDTH = $clog2(SAMPLES)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [IDX_WIDTH-1:0]       bin_idx,
  input  logic [SAMPLES*WIDTH-1:0]   src_real,
  input  logic [SAMPLES*WIDTH-1:0]   src_imag,
  output logic                       busy,
  output logic                       ready,
  output logic [WIDTH-1:0]           dft_real,
  output logic [WIDTH-1:0]           dft_imag,
  output logic                       sat
);

  localparam int unsigned       ACC_W  = acc_width(WIDTH, TW_WIDTH, IDX_WIDTH);
  localparam int unsigned       PROD_W = WIDTH + TW_WIDTH;
  localparam logic signed [63:0] RND   = 64'sd1 <<< (TW_FRAC - 1);

  if (SAMPLES < 4 || (SAMPLES & (SAMPLES - 1)) != 0 || FRAC >= WIDTH) begin : g_bad_param
    $error("dft_bin_engine: SAMPLES must be a power of two >= 4 and FRAC < WIDTH");
  end

  state_e                     state_q, state_d;
  logic [IDX_WIDTH-1:0]       k_q, k_d, n_q, n_d, m_q, m_d;
  logic [1:0]                 drain_q, drain_d;
  logic                       busy_q, busy_d, ready_q, ready_d, sat_q, sat_d;
  logic signed [WIDTH-1:0]    dft_real_q, dft_real_d, dft_imag_q, dft_imag_d;
  logic                       s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic signed [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic signed [TW_WIDTH-1:0] cos_q, sin_q;
  logic signed [PROD_W-1:0]   p_ac_q, p_ac_d, p_bs_q, p_bs_d, p_bc_q, p_bc_d, p_as_q, p_as_d;
  logic signed [ACC_W-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [63:0]         re_rnd, im_rnd;
  logic                       re_clip, im_clip;

  dft_twiddle_rom #(
    .SAMPLES   (SAMPLES),
    .TW_WIDTH  (TW_WIDTH),
    .TW_FRAC   (TW_FRAC),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (m_q),
    .cos_o   (cos_q),
    .sin_o   (sin_q)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    m_d        = m_q;
    drain_d    = drain_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    sat_d      = sat_q;
    dft_real_d = dft_real_q;
    dft_imag_d = dft_imag_q;
    re_clip    = 1'b0;
    im_clip    = 1'b0;

    // S1 sample mux (ROM read runs alongside), S2 products, S3 accumulate.
    s1_vld_d = (state_q == RUN);
    a_d      = src_real[n_q*WIDTH +: WIDTH];
    b_d      = src_imag[n_q*WIDTH +: WIDTH];
    s2_vld_d = s1_vld_q;
    p_ac_d   = PROD_W'(a_q) * PROD_W'(cos_q);
    p_bs_d   = PROD_W'(b_q) * PROD_W'(sin_q);
    p_bc_d   = PROD_W'(b_q) * PROD_W'(cos_q);
    p_as_d   = PROD_W'(a_q) * PROD_W'(sin_q);
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (s2_vld_q) begin
      acc_re_d = acc_re_q + ACC_W'(p_ac_q) + ACC_W'(p_bs_q);
      acc_im_d = acc_im_q + ACC_W'(p_bc_q) - ACC_W'(p_as_q);
    end

    // Round half up back to sample scale.
    re_rnd = (64'(acc_re_q) + RND) >>> TW_FRAC;
    im_rnd = (64'(acc_im_q) + RND) >>> TW_FRAC;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          k_d      = bin_idx;
          n_d      = '0;
          m_d      = '0;
          acc_re_d = '0;
          acc_im_d = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        n_d = n_q + IDX_WIDTH'(1);
        m_d = m_q + k_q;
        if (n_q == IDX_WIDTH'(SAMPLES - 1)) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd2) state_d = DONE;
        else                 drain_d = drain_q + 2'd1;
      end
      DONE: begin
        dft_real_d = WIDTH'(saturate(re_rnd, WIDTH, re_clip));
        dft_imag_d = WIDTH'(saturate(im_rnd, WIDTH, im_clip));
        sat_d      = re_clip | im_clip;
        ready_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      n_q        <= '0;
      m_q        <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      sat_q      <= 1'b0;
      dft_real_q <= '0;
      dft_imag_q <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      p_ac_q     <= '0;
      p_bs_q     <= '0;
      p_bc_q     <= '0;
      p_as_q     <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      m_q        <= m_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      sat_q      <= sat_d;
      dft_real_q <= dft_real_d;
      dft_imag_q <= dft_imag_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_ac_q     <= p_ac_d;
      p_bs_q     <= p_bs_d;
      p_bc_q     <= p_bc_d;
      p_as_q     <= p_as_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign sat      = sat_q;
  assign dft_real = dft_real_q;
  assign dft_imag = dft_imag_q;

endmodule

// File: tb/tb_dft_bin_engine.sv
// Directed plus randomized checks of dft_bin_engine against a plain-arithmetic DFT model.
module tb_dft_bin_engine;

  localparam int N = 32;
  localparam int W = 24;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [4:0]     bin_idx = '0;
  logic [N*W-1:0] src_real = '0;
  logic [N*W-1:0] src_imag = '0;
  logic           busy, ready, sat;
  logic [W-1:0]   dft_real, dft_imag;

  int vectors = 0;
  int miscompares = 0;
  int xr[N];
  int xi[N];

  always #5 clk = ~clk;

  dft_bin_engine dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin_idx  (bin_idx),
    .src_real (src_real),
    .src_imag (src_imag),
    .busy     (busy),
    .ready    (ready),
    .dft_real (dft_real),
    .dft_imag (dft_imag),
    .sat      (sat)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($rtoi(x + 0.5));
    return -longint'($rtoi(0.5 - x));
  endfunction

  function automatic longint iabs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  // X[k] with rounded Q16 twiddles, round half up, clip to W bits.
  function automatic void model(input int k, output longint er, output longint ei,
                                output logic es);
    longint sr, si, c, s, hi;
    int m;
    real ang;
    sr = 0;
    si = 0;
    for (int n = 0; n < N; n++) begin
      m   = (n * k) % N;
      ang = 2.0 * 3.14159265358979323846 * real'(m) / real'(N);
      c   = rnd(65536.0 * $cos(ang));
      s   = rnd(65536.0 * $sin(ang));
      sr += longint'(xr[n]) * c + longint'(xi[n]) * s;
      si += longint'(xi[n]) * c - longint'(xr[n]) * s;
    end
    sr = (sr + 32768) >>> 16;
    si = (si + 32768) >>> 16;
    hi = 8388607;
    es = 1'b0;
    if (sr > hi) begin sr = hi; es = 1'b1; end
    if (sr < -hi - 1) begin sr = -hi - 1; es = 1'b1; end
    if (si > hi) begin si = hi; es = 1'b1; end
    if (si < -hi - 1) begin si = -hi - 1; es = 1'b1; end
    er = sr;
    ei = si;
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      src_real[i*W +: W] = W'(xr[i]);
      src_imag[i*W +: W] = W'(xi[i]);
    end
  endtask

  task automatic fill_random(input int amp);
    for (int i = 0; i < N; i++) begin
      xr[i] = int'($urandom_range(2 * amp, 0)) - amp;
      xi[i] = int'($urandom_range(2 * amp, 0)) - amp;
    end
    pack();
  endtask

  // Start bin k; optionally re-pulse start with k2 at cycle restart_at of the run.
  task automatic run_bin(input int k, input int restart_at, input int k2, input string tag);
    longint er, ei;
    logic es;
    logic [W-1:0] prev_re, prev_im;
    int cnt;
    model(k, er, ei, es);
    prev_re = dft_real;
    prev_im = dft_imag;
    bin_idx = 5'(k);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    bin_idx = 5'($urandom);
    check({tag, "_busy_rise"}, 64'(busy), 64'(1));
    check({tag, "_ready_drop"}, 64'(ready), 64'(0));
    check({tag, "_hold_re"}, 64'(dft_real), 64'(prev_re));
    check({tag, "_hold_im"}, 64'(dft_imag), 64'(prev_im));
    cnt = 0;
    while (!ready && cnt < 200) begin
      if (cnt == restart_at) begin
        start   = 1'b1;
        bin_idx = 5'(k2);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cnt++;
    end
    check({tag, "_latency"}, 64'(cnt), 64'(N + 4));
    check({tag, "_re"}, 64'($signed(dft_real)), 64'(er));
    check({tag, "_im"}, 64'($signed(dft_imag)), 64'(ei));
    check({tag, "_sat"}, 64'(sat), 64'(es));
    check({tag, "_busy_fall"}, 64'(busy), 64'(0));
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_sat", 64'(sat), 64'(0));
    check("rst_re", 64'(dft_real), 64'(0));
    check("rst_im", 64'(dft_imag), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Impulse
    for (int i = 0; i < N; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[0] = 256;
    pack();
    run_bin(7, -1, 0, "impulse");
    check("impulse_re_abs", 64'($signed(dft_real)), 64'(256));
    check("impulse_im_abs", 64'($signed(dft_imag)), 64'(0));

    // DC
    for (int i = 0; i < N; i++) begin xr[i] = 256; xi[i] = 0; end
    pack();
    run_bin(0, -1, 0, "dc_k0");
    check("dc_k0_abs", 64'($signed(dft_real)), 64'(8192));
    run_bin(5, -1, 0, "dc_k5");
    check("dc_k5_small", 64'(iabs(longint'($signed(dft_real))) <= 2 &&
                             iabs(longint'($signed(dft_imag))) <= 2), 64'(1));

    // Tone at bin 3
    for (int i = 0; i < N; i++) begin
      xr[i] = int'(rnd(256.0 * $cos(2.0 * 3.14159265358979323846 * 3.0 * real'(i) / 32.0)));
      xi[i] = 0;
    end
    pack();
    run_bin(3, -1, 0, "tone_k3");
    check("tone_k3_near", 64'(iabs(longint'($signed(dft_real)) - 4096) <= 2 &&
                             iabs(longint'($signed(dft_imag))) <= 2), 64'(1));
    run_bin(29, -1, 0, "tone_k29");
    check("tone_k29_near", 64'(iabs(longint'($signed(dft_real)) - 4096) <= 2 &&
                              iabs(longint'($signed(dft_imag))) <= 2), 64'(1));
    run_bin(4, -1, 0, "tone_k4");
    check("tone_k4_small", 64'(iabs(longint'($signed(dft_real))) <= 2 &&
                              iabs(longint'($signed(dft_imag))) <= 2), 64'(1));

    // Saturation then a clean result
    for (int i = 0; i < N; i++) begin xr[i] = 8388607; xi[i] = 0; end
    pack();
    run_bin(0, -1, 0, "sat_max");
    check("sat_max_abs", 64'($signed(dft_real)), 64'(8388607));
    check("sat_max_flag", 64'(sat), 64'(1));
    for (int i = 0; i < N; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[0] = 1;
    pack();
    run_bin(0, -1, 0, "sat_clear");
    check("sat_clear_re", 64'($signed(dft_real)), 64'(1));

    // Start while busy must be ignored
    fill_random(100000);
    run_bin(9, 5, 14, "restart_ignored");

    // Reset mid-run, then recover
    fill_random(50000);
    bin_idx = 5'd11;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("midrst_busy_before", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_ready", 64'(ready), 64'(0));
    check("midrst_re", 64'(dft_real), 64'(0));
    check("midrst_im", 64'(dft_imag), 64'(0));
    check("midrst_sat", 64'(sat), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_bin(11, -1, 0, "after_rst");

    // Randomized bins and amplitudes, including saturating ones
    for (int t = 0; t < 10; t++) begin
      case (t % 3)
        0:       fill_random(1000);
        1:       fill_random(400000);
        default: fill_random(8388607);
      endcase
      run_bin(int'($urandom_range(31, 0)), -1, 0, $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
